// File: rtl/chess_turn_ctrl.sv
// Chess clock turn controller: selects which player's clock runs, generates the
// shared tick, handles pause/resume, timeouts, move counting and increment pulses.
module chess_turn_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MOVE_CNT_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  game_start,
    input  logic                  move_done,
    input  logic                  pause_req,
    input  logic                  time_up_w,
    input  logic                  time_up_b,
    output logic                  run_w,
    output logic                  run_b,
    output logic                  tick,
    output logic                  inc_w,
    output logic                  inc_b,
    output logic                  turn,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic                  game_over,
    output logic [1:0]            winner
);

    localparam int TC    = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int DIV_W = (TC > 0) ? $clog2(TC + 1) : 1;
    localparam logic [DIV_W-1:0] TC_V = DIV_W'(TC);

    typedef enum logic [2:0] {
        IDLE,
        RUN_W,
        RUN_B,
        PAUSE_W,
        PAUSE_B,
        OVER
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             white_side;
    logic             running;
    logic             timeout;
    logic             counting;

    always_comb begin
        white_side = (state == RUN_W) || (state == PAUSE_W);
        running    = (state == RUN_W) || (state == RUN_B);
        timeout    = (white_side && time_up_w) ||
                     (((state == RUN_B) || (state == PAUSE_B)) && time_up_b);
        // The divider only advances on edges where a clock keeps running, including
        // a turn swap, so tick spacing is unaffected by moves and pauses.
        counting   = running && !game_start && !timeout && !pause_req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div        <= '0;
            run_w      <= 1'b0;
            run_b      <= 1'b0;
            tick       <= 1'b0;
            inc_w      <= 1'b0;
            inc_b      <= 1'b0;
            turn       <= 1'b0;
            move_count <= '0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            inc_w <= 1'b0;
            inc_b <= 1'b0;
            tick  <= 1'b0;
            if (counting) begin
                div  <= (div == TC_V) ? '0 : div + DIV_W'(1);
                tick <= (div == TC_V);
            end

            if (game_start) begin
                state      <= RUN_W;
                div        <= '0;
                run_w      <= 1'b1;
                run_b      <= 1'b0;
                turn       <= 1'b0;
                move_count <= '0;
                game_over  <= 1'b0;
                winner     <= 2'b00;
            end else if (timeout) begin
                state     <= OVER;
                run_w     <= 1'b0;
                run_b     <= 1'b0;
                game_over <= 1'b1;
                winner    <= white_side ? 2'b10 : 2'b01;
            end else begin
                case (state)
                    RUN_W: begin
                        if (pause_req) begin
                            state <= PAUSE_W;
                            run_w <= 1'b0;
                        end else if (move_done) begin
                            state <= RUN_B;
                            run_w <= 1'b0;
                            run_b <= 1'b1;
                            turn  <= 1'b1;
                            inc_w <= 1'b1;
                            if (move_count != '1)
                                move_count <= move_count + MOVE_CNT_W'(1);
                        end
                    end
                    RUN_B: begin
                        if (pause_req) begin
                            state <= PAUSE_B;
                            run_b <= 1'b0;
                        end else if (move_done) begin
                            state <= RUN_W;
                            run_b <= 1'b0;
                            run_w <= 1'b1;
                            turn  <= 1'b0;
                            inc_b <= 1'b1;
                            if (move_count != '1)
                                move_count <= move_count + MOVE_CNT_W'(1);
                        end
                    end
                    PAUSE_W: begin
                        if (pause_req) begin
                            state <= RUN_W;
                            run_w <= 1'b1;
                        end
                    end
                    PAUSE_B: begin
                        if (pause_req) begin
                            state <= RUN_B;
                            run_b <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Directed bench for chess_turn_ctrl: tick cadence, turn swap, pause, timeout,
// saturation/restart and asynchronous reset.
module tb_chess_turn_ctrl;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int TICK_HZ     = 100;
    localparam int MOVE_CNT_W  = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  game_start;
    logic                  move_done;
    logic                  pause_req;
    logic                  time_up_w;
    logic                  time_up_b;
    logic                  run_w;
    logic                  run_b;
    logic                  tick;
    logic                  inc_w;
    logic                  inc_b;
    logic                  turn;
    logic [MOVE_CNT_W-1:0] move_count;
    logic                  game_over;
    logic [1:0]            winner;

    int total = 0;
    int bad   = 0;
    int nt;
    int ni;

    always #5 clk = ~clk;

    chess_turn_ctrl #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TICK_HZ    (TICK_HZ),
        .MOVE_CNT_W (MOVE_CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .game_start(game_start),
        .move_done (move_done),
        .pause_req (pause_req),
        .time_up_w (time_up_w),
        .time_up_b (time_up_b),
        .run_w     (run_w),
        .run_b     (run_b),
        .tick      (tick),
        .inc_w     (inc_w),
        .inc_b     (inc_b),
        .turn      (turn),
        .move_count(move_count),
        .game_over (game_over),
        .winner    (winner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, counting tick pulses and increment pulses seen.
    task automatic run_n(input int n, output int ticks, output int incs);
        ticks = 0;
        incs  = 0;
        for (int k = 0; k < n; k++) begin
            step();
            ticks += int'(tick);
            incs  += int'(inc_w) + int'(inc_b);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        game_start = 1'b0;
        move_done  = 1'b0;
        pause_req  = 1'b0;
        time_up_w  = 1'b0;
        time_up_b  = 1'b0;
        step();
        step();
        chk("rst_run", {run_w, run_b}, 0);
        chk("rst_pulses", {tick, inc_w, inc_b}, 0);
        chk("rst_turn", turn, 0);
        chk("rst_count", move_count, 0);
        chk("rst_over", {game_over, winner}, 0);
        reset_n = 1'b1;

        // Idle ignores moves and pauses
        move_done = 1'b1;
        pause_req = 1'b1;
        step();
        move_done = 1'b0;
        pause_req = 1'b0;
        step();
        chk("idle_ignore", {run_w, run_b, move_count}, 0);

        // Start: White runs, tick every 10 clocks
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        chk("start_run_w", run_w, 1);
        chk("start_run_b", run_b, 0);
        chk("start_turn", turn, 0);
        run_n(9, nt, ni);
        chk("tick_gap1", nt, 0);
        step();
        chk("tick_first", tick, 1);
        run_n(9, nt, ni);
        chk("tick_gap2", nt, 0);
        step();
        chk("tick_second", tick, 1);

        // Turn swap mid-interval
        run_n(3, nt, ni);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        chk("swap_run", {run_w, run_b}, 2'b01);
        chk("swap_turn", turn, 1);
        chk("swap_inc", {inc_w, inc_b}, 2'b10);
        chk("swap_count", move_count, 1);
        step();
        chk("swap_inc_end", inc_w, 0);
        run_n(4, nt, ni);
        chk("swap_tick_gap", nt, 0);
        step();
        chk("swap_tick", tick, 1);

        // Black moves back to White
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        chk("swapb_run", {run_w, run_b}, 2'b10);
        chk("swapb_inc", {inc_w, inc_b}, 2'b01);
        chk("swapb_count", move_count, 2);

        // Pause with divider at 4, ignore move while paused
        run_n(3, nt, ni);
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        chk("pause_run", {run_w, run_b}, 0);
        chk("pause_turn", turn, 0);
        nt = 0;
        ni = 0;
        for (int i = 0; i < 50; i++) begin
            move_done = (i == 10);
            step();
            nt += int'(tick);
            ni += int'(inc_w) + int'(inc_b);
        end
        move_done = 1'b0;
        chk("pause_ticks", nt, 0);
        chk("pause_incs", ni, 0);
        chk("pause_count", move_count, 2);
        chk("pause_hold", {run_w, turn}, 0);

        // Resume: first tick 6 clocks later
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        chk("resume_run", run_w, 1);
        run_n(5, nt, ni);
        chk("resume_gap", nt, 0);
        step();
        chk("resume_tick", tick, 1);

        // Timeout of White with simultaneous move; Black's flag ignored
        time_up_b = 1'b1;
        step();
        time_up_b = 1'b0;
        chk("tub_ignored", {run_w, game_over, winner}, 4'b1000);
        time_up_w = 1'b1;
        move_done = 1'b1;
        step();
        time_up_w = 1'b0;
        move_done = 1'b0;
        chk("tow_over", {game_over, winner}, 3'b110);
        chk("tow_run", {run_w, run_b}, 0);
        chk("tow_inc", {inc_w, inc_b}, 0);
        chk("tow_count", move_count, 2);
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        chk("over_pause", {run_w, run_b, game_over, winner}, 5'b00110);

        // Restart from OVER, then Black timeout beats move
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        chk("restart_run", run_w, 1);
        chk("restart_clear", {game_over, winner, move_count, turn}, 0);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        chk("b_run", {run_b, move_count}, 3'b101);
        time_up_w = 1'b1;
        step();
        time_up_w = 1'b0;
        chk("tuw_ignored", {run_b, game_over, winner}, 4'b1000);
        time_up_b = 1'b1;
        move_done = 1'b1;
        step();
        time_up_b = 1'b0;
        move_done = 1'b0;
        chk("tob_over", {game_over, winner}, 3'b101);
        chk("tob_inc", {inc_w, inc_b}, 0);
        chk("tob_count", move_count, 1);
        chk("tob_run", {run_w, run_b}, 0);

        // Saturation after five moves
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            move_done = 1'b1;
            step();
            move_done = 1'b0;
            step();
        end
        chk("sat_count", move_count, 3);
        chk("sat_side", {run_w, run_b, turn}, 3'b011);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_run", {run_w, run_b}, 0);
        chk("areset_state", {turn, move_count, game_over, winner}, 0);
        #2;
        reset_n = 1'b1;
        run_n(25, nt, ni);
        chk("post_reset_pulses", nt + ni, 0);
        chk("post_reset_run", {run_w, run_b}, 0);
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        chk("post_reset_start", {run_w, run_b}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
